npc_exec_sequencer: RTL and testbench

//  Multi-cycle control FSM for the NPC core; sequences fetch, decode, execute, memory and writeback.

---
 rtl/npc_exec_sequencer.sv | 174 +++++++++++++++++
 tb/tb_npc_exec_sequencer.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/npc_exec_sequencer.sv
// npc_exec_sequencer: multi-cycle fetch/decode/execute/memory/writeback control FSM for the NPC core.
//
// Build option: define SEQ_PERF_CNT_EN to add the cycle_cnt/retire_cnt counters.
// When it is left undefined, both counter outputs are tied to 0.
//
// Ports
//    clk, rst_n                               clock and asynchronous active-low reset
//    ifu_req_valid/ready, ifu_rsp_valid/inst  instruction fetch handshake
//    inst_q                                   latched instruction for the decoder LUT
//    micro_cmd, lut_hit, is_ebreak            decoder results for inst_q
//    micro_q                                  micro command latched in DECODE
//    lsu_req_valid/ready/we, lsu_rsp_valid    load/store handshake
//    rf_we, pc_we                             one-cycle writeback strobes
//    halted, halt_code                        sticky halt (0 ebreak, 1 illegal, 2 bus timeout)
//    cycle_cnt, retire_cnt                    performance counters (build option)
//
// micro_q layout: {REGEN,PCJEN,PCREN,MWEN[1:0],MREN[1:0],ALUOP[2:0],UNSIGN,IMM_TYPE[2:0]}
module npc_exec_sequencer #(
   parameter int INST_W    = 32,
   parameter int MICRO_LEN = 14,
   parameter int TIMEOUT_W = 8,
   parameter int CNT_W     = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   output logic                 ifu_req_valid,
   input  logic                 ifu_req_ready,
   input  logic                 ifu_rsp_valid,
   input  logic [INST_W-1:0]    ifu_rsp_inst,
   output logic [INST_W-1:0]    inst_q,
   input  logic [MICRO_LEN-1:0] micro_cmd,
   input  logic                 lut_hit,
   input  logic                 is_ebreak,
   output logic [MICRO_LEN-1:0] micro_q,
   output logic                 lsu_req_valid,
   input  logic                 lsu_req_ready,
   output logic                 lsu_req_we,
   input  logic                 lsu_rsp_valid,
   output logic                 rf_we,
   output logic                 pc_we,
   output logic                 halted,
   output logic [1:0]           halt_code,
   output logic [CNT_W-1:0]     cycle_cnt,
   output logic [CNT_W-1:0]     retire_cnt
);
   typedef enum logic [3:0] {
      S_IDLE, S_FETCH_REQ, S_FETCH_WAIT, S_DECODE, S_EXEC,
      S_MEM_REQ, S_MEM_WAIT, S_WB, S_HALT
   } state_e;

   localparam logic [TIMEOUT_W-1:0] WD_MAX = {TIMEOUT_W{1'b1}};

   state_e                 state_q, state_d;
   logic [INST_W-1:0]      inst_d;
   logic [MICRO_LEN-1:0]   micro_d;
   logic [1:0]             code_q, code_d;
   logic [TIMEOUT_W-1:0]   wdog_q, wdog_d;
   logic                   wdog_run, timeout, mem_op;

   assign wdog_run = state_q inside {S_FETCH_REQ, S_FETCH_WAIT, S_MEM_REQ, S_MEM_WAIT};
   // The cycle that would bring the watchdog to its limit is the last one allowed to wait.
   assign timeout  = wdog_run && (wdog_q == WD_MAX - 1'b1);
   assign mem_op   = |micro_q[10:7];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         inst_q  <= '0;
         micro_q <= '0;
         code_q  <= '0;
         wdog_q  <= '0;
      end else begin
         state_q <= state_d;
         inst_q  <= inst_d;
         micro_q <= micro_d;
         code_q  <= code_d;
         wdog_q  <= wdog_d;
      end
   end

   always_comb begin
      state_d = state_q;
      inst_d  = inst_q;
      micro_d = micro_q;
      code_d  = code_q;
      wdog_d  = (wdog_run && wdog_q != WD_MAX) ? wdog_q + 1'b1 : wdog_q;
      // Handshakes are tested before the timeout so a response on the last cycle still wins.
      case (state_q)
         S_IDLE: begin
            state_d = S_FETCH_REQ;
            wdog_d  = '0;
         end
         S_FETCH_REQ: begin
            if (ifu_req_ready) state_d = S_FETCH_WAIT;
            else if (timeout) begin
               state_d = S_HALT;
               code_d  = 2'd2;
            end
         end
         S_FETCH_WAIT: begin
            if (ifu_rsp_valid) begin
               state_d = S_DECODE;
               inst_d  = ifu_rsp_inst;
            end else if (timeout) begin
               state_d = S_HALT;
               code_d  = 2'd2;
            end
         end
         S_DECODE: begin
            if (!lut_hit) begin
               state_d = S_HALT;
               code_d  = 2'd1;
            end else if (is_ebreak) begin
               state_d = S_HALT;
               code_d  = 2'd0;
            end else begin
               state_d = S_EXEC;
               micro_d = micro_cmd;
            end
         end
         S_EXEC: begin
            state_d = mem_op ? S_MEM_REQ : S_WB;
            wdog_d  = '0;
         end
         S_MEM_REQ: begin
            if (lsu_req_ready) state_d = S_MEM_WAIT;
            else if (timeout) begin
               state_d = S_HALT;
               code_d  = 2'd2;
            end
         end
         S_MEM_WAIT: begin
            if (lsu_rsp_valid) state_d = S_WB;
            else if (timeout) begin
               state_d = S_HALT;
               code_d  = 2'd2;
            end
         end
         S_WB: begin
            state_d = S_FETCH_REQ;
            wdog_d  = '0;
         end
         default: state_d = S_HALT;
      endcase
   end

   assign ifu_req_valid = state_q == S_FETCH_REQ;
   assign lsu_req_valid = state_q == S_MEM_REQ;
   assign lsu_req_we    = lsu_req_valid && |micro_q[10:9];
   assign pc_we         = state_q == S_WB;
   assign rf_we         = pc_we && micro_q[MICRO_LEN-1];
   assign halted        = state_q == S_HALT;
   assign halt_code     = code_q;

`ifdef SEQ_PERF_CNT_EN
   logic [CNT_W-1:0] cyc_q, ret_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cyc_q <= '0;
         ret_q <= '0;
      end else begin
         if (!halted) cyc_q <= cyc_q + 1'b1;
         if (pc_we) ret_q <= ret_q + 1'b1;
      end
   end

   assign cycle_cnt  = cyc_q;
   assign retire_cnt = ret_q;
`else
   assign cycle_cnt  = '0;
   assign retire_cnt = '0;
`endif
endmodule

// File: tb/tb_npc_exec_sequencer.sv
// tb_npc_exec_sequencer: scoreboard bench for the NPC execution sequencer.
module tb_npc_exec_sequencer;
   localparam int TW = 4;
   localparam logic [31:0] ADDI = 32'h00500093;

   logic        clk = 1'b0, rst_n = 1'b0;
   logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid;
   logic [31:0] ifu_rsp_inst, inst_q;
   logic [13:0] micro_cmd, micro_q;
   logic        lut_hit, is_ebreak;
   logic        lsu_req_valid, lsu_req_ready, lsu_req_we, lsu_rsp_valid;
   logic        rf_we, pc_we, halted;
   logic [1:0]  halt_code;
   logic [31:0] cycle_cnt, retire_cnt;

   int checks = 0, errors = 0, ncyc = 0, halt_n = 0;

   typedef struct {bit halt; logic [1:0] code; bit rf; int lat;} exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;

   npc_exec_sequencer #(.TIMEOUT_W(TW)) dut (
      .clk(clk), .rst_n(rst_n),
      .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
      .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_inst(ifu_rsp_inst), .inst_q(inst_q),
      .micro_cmd(micro_cmd), .lut_hit(lut_hit), .is_ebreak(is_ebreak), .micro_q(micro_q),
      .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_we(lsu_req_we),
      .lsu_rsp_valid(lsu_rsp_valid), .rf_we(rf_we), .pc_we(pc_we),
      .halted(halted), .halt_code(halt_code),
      .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      ncyc++;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      {ifu_req_ready, ifu_rsp_valid, lsu_req_ready, lsu_rsp_valid, lut_hit, is_ebreak} = '0;
      ifu_rsp_inst = '0;
      micro_cmd = '0;
      step();
      step();
      check("rst_outs", {ifu_req_valid, lsu_req_valid, lsu_req_we, rf_we, pc_we, halted, halt_code}, 8'd0);
      check("rst_regs", {inst_q, micro_q}, 46'd0);
      rst_n = 1'b1;
      ncyc = 0;
   endtask

   // One instruction: fetch response on wait cycle frsp (0 = never), lstall cycles of lsu back-pressure.
   task automatic run(input logic [31:0] ins, input logic [13:0] mc, input bit hit, input bit eb,
                      input int frsp, input int lstall, input bit stray, input bit abort);
      exp_t e, o;
      bit mem = |mc[10:7];
      bit lacc = 1'b0, done = 1'b0;
      int cyc = 0, held = 0;
      e.halt = !hit || eb || frsp == 0;
      e.code = (frsp == 0) ? 2'd2 : !hit ? 2'd1 : 2'd0;
      e.rf   = mc[13] && !e.halt;
      e.lat  = (frsp == 0) ? (1 << TW) : e.halt ? frsp + 2 : mem ? frsp + 5 + lstall : frsp + 3;
      if (!abort) sb.push_back(e);
      micro_cmd = mc;
      lut_hit   = hit;
      is_ebreak = eb;
      for (int i = 0; i < 64 && !done; i++) begin
         step();
         if (cyc == 0 && ifu_req_valid) begin
            cyc = 1;
            check("pc_we_pulse", pc_we, 1'b0);
         end else if (cyc != 0) cyc++;
         ifu_req_ready = ifu_req_valid;
         ifu_rsp_valid = (cyc == frsp) || (stray && cyc == 1);
         ifu_rsp_inst  = (cyc == 1) ? ~ins : ins;
         if (frsp != 0 && cyc == frsp + 1) check("inst_q", inst_q, ins);
         if (!e.halt && cyc == frsp + 2) check("micro_q", micro_q, mc);
         lsu_rsp_valid = lacc;
         lacc = 1'b0;
         lsu_req_ready = 1'b0;
         if (lsu_req_valid) begin
            held++;
            check("lsu_we", lsu_req_we, |mc[10:9]);
            lsu_req_ready = held > lstall;
            lacc = lsu_req_ready;
            if (abort && held == 2) begin
               rst_n = 1'b0;
               #1 check("rst_async", lsu_req_valid, 1'b0);
               done = 1'b1;
            end
         end
         if (!done && (pc_we || halted)) begin
            o.halt = halted;
            o.code = halt_code;
            o.rf   = rf_we;
            o.lat  = cyc;
            if (sb.size() == 0) check("sb_empty", 1'b1, 1'b0);
            else begin
               e = sb.pop_front();
               check("kind", o.halt, e.halt);
               check("halt_code", o.code, e.code);
               check("rf_we", o.rf, e.rf);
               check("latency", o.lat, e.lat);
            end
            if (!o.halt) check("lsu_hold", held, mem ? lstall + 1 : 0);
            done = 1'b1;
         end
      end
      if (!done) check("cycle_budget", 1'b0, 1'b1);
      {ifu_req_ready, ifu_rsp_valid, lsu_req_ready, lsu_rsp_valid} = '0;
   endtask

   task automatic absorb(input logic [1:0] code);
      for (int i = 0; i < 4; i++) begin
         step();
         ifu_rsp_valid = 1'b1;
         lsu_rsp_valid = 1'b1;
         check("halt_hold", {halted, halt_code, ifu_req_valid, lsu_req_valid, rf_we, pc_we}, {1'b1, code, 4'b0});
      end
      ifu_rsp_valid = 1'b0;
      lsu_rsp_valid = 1'b0;
   endtask

   initial begin
      do_reset();
      run(ADDI, 14'h2001, 1, 0, 2, 0, 0, 0);
      run(32'h00002083, 14'h2181, 1, 0, 2, 3, 0, 0);
      run(32'h0020a023, 14'h0602, 1, 0, 2, 0, 0, 0);
      run(ADDI, 14'h2001, 1, 0, 15, 0, 1, 0);
      for (int k = 0; k < 3; k++)
         run($urandom, 14'($urandom) & 14'h387f, 1, 0, $urandom_range(2, 14), 0, 1, 0);
      for (int k = 0; k < 3; k++)
         run($urandom, (14'($urandom) & 14'h3fff) | 14'h0080, 1, 0, 2, $urandom_range(0, 4), 0, 0);

      do_reset();
      for (int k = 0; k < 3; k++) run(ADDI, 14'h2001, 1, 0, 2, 0, 0, 0);
      run(32'h00100073, 14'h0000, 1, 1, 2, 0, 0, 0);
      halt_n = ncyc;
      absorb(2'd0);
`ifdef SEQ_PERF_CNT_EN
      check("retire_cnt", retire_cnt, 3);
      check("cycle_cnt_frozen", cycle_cnt, halt_n);
`else
      check("retire_cnt_tied", retire_cnt, 0);
      check("cycle_cnt_tied", cycle_cnt, 0);
`endif

      do_reset();
      run(32'hffffffff, 14'h2001, 0, 1, 2, 0, 0, 0);
      absorb(2'd1);

      do_reset();
      run(ADDI, 14'h2001, 1, 0, 0, 0, 0, 0);
      absorb(2'd2);

      do_reset();
      run(32'h00002083, 14'h2181, 1, 0, 2, 10, 0, 1);
      do_reset();
      run(ADDI, 14'h2001, 1, 0, 2, 0, 0, 0);

      check("sb_drained", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
